// File: rtl/alu_pkg.sv
// Shared definitions for the ALU input capture stage: default widths, button
// indices and the debounce FSM state type.
package alu_pkg;

  localparam int unsigned NB_DATA_DFLT = 4;
  localparam int unsigned NB_OP_DFLT   = 6;
  localparam int unsigned NB_SW_DFLT   = 6;

  localparam int unsigned BTN_A  = 0;
  localparam int unsigned BTN_B  = 1;
  localparam int unsigned BTN_OP = 2;

  typedef enum logic {
    DB_STABLE,
    DB_COUNT
  } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: two-flop synchronizer, debounce FSM and a
// one-cycle press (rising edge) strobe.
// Configuration macro: ALU_IN_DEBOUNCE_EN. When undefined, the debounced level
// is a registered copy of the synchronizer output and DB_CYCLES is ignored.
module btn_debounce
  import alu_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("btn_debounce: DB_CYCLES must be >= 1");
  end

  logic sync1_q;
  logic sync2_q;
  logic stable_q;
  logic stable_dly_q;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef ALU_IN_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_d;

  // Debounce next-state: a level change is accepted only after it has been
  // seen for DB_CYCLES consecutive cycles; any return to the old level aborts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    unique case (state_q)
      DB_STABLE: begin
        if (sync2_q != stable_q) begin
          state_d = DB_COUNT;
          cnt_d   = CW'(1);
        end
      end
      DB_COUNT: begin
        if (sync2_q == stable_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_d = ~stable_q;
          state_d  = DB_STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounce state, counter and accepted level.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= DB_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
`else
  // Debounce bypassed: register sync2 so the pipeline depth matches the
  // debounced path with a zero-length count (press seen at edge k+3).
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= sync2_q;
    end
  end
`endif

  // Delayed copy of the accepted level for edge detection.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_dly_q <= 1'b0;
    end else begin
      stable_dly_q <= stable_q;
    end
  end

  // Only the press edge matters; release edges are ignored.
  assign o_press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/alu_input_latch.sv
// Operand/opcode capture stage in front of the ALU: each debounced button
// press latches the switch bus into Dato A, Dato B or the operation register.
// Configuration macro: ALU_IN_DEBOUNCE_EN (enables the per-button debounce FSM).
module alu_input_latch
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA   = NB_DATA_DFLT,
  parameter int unsigned NB_OP     = NB_OP_DFLT,
  parameter int unsigned NB_SW     = NB_SW_DFLT,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [2:0]         i_btn,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  output logic [2:0]         o_loaded
);

  if (NB_SW < NB_DATA || NB_SW < NB_OP) begin : g_bad_sw_width
    $error("alu_input_latch: NB_SW must be >= max(NB_DATA, NB_OP)");
  end

  logic [2:0]         press;
  logic [NB_DATA-1:0] dato_a_q;
  logic [NB_DATA-1:0] dato_b_q;
  logic [NB_OP-1:0]   op_q;
  logic               valid_q;
  logic [2:0]         loaded_q;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn[i]),
      .o_press (press[i])
    );
  end

  // Capture registers; simultaneous presses all load from the same i_sw sample.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dato_a_q <= '0;
      dato_b_q <= '0;
      op_q     <= '0;
      valid_q  <= 1'b0;
      loaded_q <= '0;
    end else begin
      if (press[BTN_A])  dato_a_q <= i_sw[NB_DATA-1:0];
      if (press[BTN_B])  dato_b_q <= i_sw[NB_DATA-1:0];
      if (press[BTN_OP]) op_q     <= i_sw[NB_OP-1:0];
      valid_q  <= |press;
      loaded_q <= loaded_q | press;
    end
  end

  assign o_datoA     = dato_a_q;
  assign o_datoB     = dato_b_q;
  assign o_operation = op_q;
  assign o_valid     = valid_q;
  assign o_loaded    = loaded_q;

endmodule

// File: tb/tb_alu_input_latch.sv
// Self-checking bench for alu_input_latch. Expected loads are pushed to a
// scoreboard when a button is driven and popped on each o_valid pulse.
module tb_alu_input_latch;

  localparam int DB = 4;
`ifdef ALU_IN_DEBOUNCE_EN
  localparam int LAT = DB + 3;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [5:0] i_sw = '0;
  logic [2:0] i_btn = '0;
  logic [3:0] o_datoA;
  logic [3:0] o_datoB;
  logic [5:0] o_operation;
  logic       o_valid;
  logic [2:0] o_loaded;

  alu_input_latch #(
    .NB_DATA  (4),
    .NB_OP    (6),
    .NB_SW    (6),
    .DB_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_sw       (i_sw),
    .i_btn      (i_btn),
    .o_datoA    (o_datoA),
    .o_datoB    (o_datoB),
    .o_operation(o_operation),
    .o_valid    (o_valid),
    .o_loaded   (o_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at_edge;
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] op;
    logic [2:0] loaded;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   valid_cnt = 0;

  logic [3:0] ma = '0;
  logic [3:0] mb = '0;
  logic [5:0] mop = '0;
  logic [2:0] mld = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record an expected load: apply it to the register model and queue a snapshot.
  task automatic push(input int at, input logic [2:0] mask, input logic [5:0] sw);
    exp_t e;
    if (mask[0]) ma = sw[3:0];
    if (mask[1]) mb = sw[3:0];
    if (mask[2]) mop = sw;
    mld = mld | mask;
    e.at_edge = at;
    e.a = ma;
    e.b = mb;
    e.op = mop;
    e.loaded = mld;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every o_valid pulse must match the next expected load.
  always @(negedge clk) begin
    exp_t e;
    if (i_rst_n && o_valid) begin
      valid_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid edge=%0d got datoA=%h datoB=%h op=%h loaded=%b required no pulse",
                 cyc, o_datoA, o_datoB, o_operation, o_loaded);
      end else begin
        e = sb.pop_front();
        checks++;
        if (cyc !== e.at_edge) begin
          failures++;
          $display("FAIL load_edge got=%0d required=%0d", cyc, e.at_edge);
        end
        checks++;
        if ({o_datoA, o_datoB, o_operation, o_loaded} !== {e.a, e.b, e.op, e.loaded}) begin
          failures++;
          $display("FAIL load_value got a=%h b=%h op=%h ld=%b required a=%h b=%h op=%h ld=%b",
                   o_datoA, o_datoB, o_operation, o_loaded, e.a, e.b, e.op, e.loaded);
        end
      end
    end
  end

  task automatic test_reset();
    int vc0;
    i_rst_n = 1'b0;
    i_btn = '0;
    i_sw = 6'h3F;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_datoA, o_datoB, o_operation, o_valid, o_loaded} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got a=%h b=%h op=%h v=%b ld=%b required all zero",
               o_datoA, o_datoB, o_operation, o_valid, o_loaded);
    end
    step();
    i_rst_n = 1'b1;
    vc0 = valid_cnt;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (valid_cnt - vc0 !== 0) begin
      failures++;
      $display("FAIL idle_valid got=%0d pulses required=0", valid_cnt - vc0);
    end
    checks++;
    if ({o_datoA, o_datoB, o_operation, o_loaded} !== 17'd0) begin
      failures++;
      $display("FAIL idle_outputs got a=%h b=%h op=%h ld=%b required all zero",
               o_datoA, o_datoB, o_operation, o_loaded);
    end
  endtask

  task automatic test_press_a();
    int vc0;
    step();
    vc0 = valid_cnt;
    i_sw = 6'h0A;
    i_btn[0] = 1'b1;
    push(cyc + 1 + LAT, 3'b001, 6'h0A);
    repeat (20) step();
    i_btn[0] = 1'b0;
    repeat (DB + 12) step();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL press_a_pending got=%0d required=0", sb.size());
      sb.delete();
    end
    checks++;
    if (valid_cnt - vc0 !== 1) begin
      failures++;
      $display("FAIL press_a_pulses got=%0d required=1", valid_cnt - vc0);
    end
    checks++;
    if (o_datoA !== 4'hA || o_loaded !== 3'b001) begin
      failures++;
      $display("FAIL press_a_final got a=%h ld=%b required a=a ld=001", o_datoA, o_loaded);
    end
  endtask

  task automatic test_bounce_op();
    int vc0;
    int s0;
    int exp_pulses;
    step();
    vc0 = valid_cnt;
    i_sw = 6'h25;
    s0 = cyc + 1;
    if (DEB) begin
      push(s0 + 4 + LAT, 3'b100, 6'h25);
    end else begin
      push(s0 + LAT, 3'b100, 6'h25);
      push(s0 + 2 + LAT, 3'b100, 6'h25);
      push(s0 + 4 + LAT, 3'b100, 6'h25);
    end
    exp_pulses = DEB ? 1 : 3;
    i_btn[2] = 1'b1; step();
    i_btn[2] = 1'b0; step();
    i_btn[2] = 1'b1; step();
    i_btn[2] = 1'b0; step();
    i_btn[2] = 1'b1;
    repeat (20) step();
    i_btn[2] = 1'b0;
    repeat (DB + 12) step();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL bounce_pending got=%0d required=0", sb.size());
      sb.delete();
    end
    checks++;
    if (valid_cnt - vc0 !== exp_pulses) begin
      failures++;
      $display("FAIL bounce_pulses got=%0d required=%0d", valid_cnt - vc0, exp_pulses);
    end
    checks++;
    if (o_operation !== 6'h25 || o_loaded !== 3'b101) begin
      failures++;
      $display("FAIL bounce_final got op=%h ld=%b required op=25 ld=101", o_operation, o_loaded);
    end
  endtask

  task automatic test_glitch_b();
    int vc0;
    int exp_pulses;
    step();
    vc0 = valid_cnt;
    i_sw = 6'h3C;
    if (!DEB) push(cyc + 1 + LAT, 3'b010, 6'h3C);
    exp_pulses = DEB ? 0 : 1;
    i_btn[1] = 1'b1;
    repeat (3) step();
    i_btn[1] = 1'b0;
    repeat (DB + 12) step();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL glitch_pending got=%0d required=0", sb.size());
      sb.delete();
    end
    checks++;
    if (valid_cnt - vc0 !== exp_pulses) begin
      failures++;
      $display("FAIL glitch_pulses got=%0d required=%0d", valid_cnt - vc0, exp_pulses);
    end
    checks++;
    if (o_datoB !== mb || o_loaded !== mld) begin
      failures++;
      $display("FAIL glitch_final got b=%h ld=%b required b=%h ld=%b", o_datoB, o_loaded, mb, mld);
    end
  endtask

  task automatic test_simultaneous();
    int vc0;
    step();
    vc0 = valid_cnt;
    i_sw = 6'h07;
    i_btn[1:0] = 2'b11;
    push(cyc + 1 + LAT, 3'b011, 6'h07);
    repeat (20) step();
    i_btn[1:0] = 2'b00;
    repeat (DB + 12) step();
    // Switches move with no press: registers must hold.
    i_sw = 6'h1E;
    repeat (10) step();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL simul_pending got=%0d required=0", sb.size());
      sb.delete();
    end
    checks++;
    if (valid_cnt - vc0 !== 1) begin
      failures++;
      $display("FAIL simul_pulses got=%0d required=1", valid_cnt - vc0);
    end
    checks++;
    if (o_datoA !== 4'h7 || o_datoB !== 4'h7 || o_loaded[1:0] !== 2'b11) begin
      failures++;
      $display("FAIL simul_final got a=%h b=%h ld=%b required a=7 b=7 ld=x11",
               o_datoA, o_datoB, o_loaded);
    end
  endtask

  task automatic test_reset_midcount();
    int vc0;
    step();
    i_sw = 6'h09;
    i_btn[0] = 1'b1;
    step();
    step();
    i_rst_n = 1'b0;
    ma = '0;
    mb = '0;
    mop = '0;
    mld = '0;
    #1;
    checks++;
    if ({o_datoA, o_datoB, o_operation, o_valid, o_loaded} !== 18'd0) begin
      failures++;
      $display("FAIL midreset_async got a=%h b=%h op=%h v=%b ld=%b required all zero",
               o_datoA, o_datoB, o_operation, o_valid, o_loaded);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({o_datoA, o_datoB, o_operation, o_valid, o_loaded} !== 18'd0) begin
      failures++;
      $display("FAIL midreset_held got a=%h b=%h op=%h v=%b ld=%b required all zero",
               o_datoA, o_datoB, o_operation, o_valid, o_loaded);
    end
    step();
    vc0 = valid_cnt;
    i_rst_n = 1'b1;
    push(cyc + 1 + LAT, 3'b001, 6'h09);
    repeat (20) step();
    i_btn[0] = 1'b0;
    repeat (DB + 12) step();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL midreset_pending got=%0d required=0", sb.size());
      sb.delete();
    end
    checks++;
    if (valid_cnt - vc0 !== 1) begin
      failures++;
      $display("FAIL midreset_pulses got=%0d required=1", valid_cnt - vc0);
    end
    checks++;
    if (o_datoA !== 4'h9 || o_datoB !== 4'h0 || o_operation !== 6'h00 || o_loaded !== 3'b001) begin
      failures++;
      $display("FAIL midreset_final got a=%h b=%h op=%h ld=%b required a=9 b=0 op=00 ld=001",
               o_datoA, o_datoB, o_operation, o_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_press_a();
    test_bounce_op();
    test_glitch_b();
    test_simultaneous();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
